// File: rtl/lfsr_rand_server_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_rand_server_if
// Description : Requester-facing bundle of the shared LFSR random server:
//               per-requester valid/range inputs, one-hot ready/response
//               pulses, shared result bus and busy flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_rand_server_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid_i;
    logic [32*N_REQ-1:0] req_min_i;
    logic [32*N_REQ-1:0] req_max_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic [N_REQ-1:0]    rsp_valid_o;
    logic [31:0]         rsp_data_o;
    logic                busy_o;

    // Requester side (traffic generators, testbench)
    modport master (
        output req_valid_i, req_min_i, req_max_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );

    // Server side
    modport slave (
        input  req_valid_i, req_min_i, req_max_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_rand_server.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_rand_server
// Description : One 32-bit XNOR LFSR (taps 32,22,2,1) shared round-robin
//               among N_REQ requesters. Each accepted request consumes one
//               LFSR step, reduced into [min, max] by a 32-cycle restoring
//               remainder unit. One request in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_rand_server #(
    parameter int          N_REQ = 4,
    parameter logic [31:0] SEED  = 32'hAE1F_B42C
) (
    input  wire logic         clk,
    input  wire logic         rst,
    lfsr_rand_server_if.slave bus
);

    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_step = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam logic [N_REQ-1:0]   c_one_hot0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [c_idx_w-1:0] c_rr_init  = c_idx_w'(N_REQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [31:0]        r_lfsr;
    logic [c_idx_w-1:0] r_rr_last;
    logic [c_idx_w-1:0] r_owner;
    logic [31:0]        r_min;
    logic [31:0]        r_max;
    logic [31:0]        r_dividend;
    logic [32:0]        r_span;
    logic [31:0]        r_rem;
    logic               r_bypass;
    logic [4:0]         r_div_cnt;
    logic [31:0]        r_rsp_data;

    logic [31:0]        w_min_arr [N_REQ];
    logic [31:0]        w_max_arr [N_REQ];
    logic               w_any_req;
    logic [c_idx_w-1:0] w_grant_idx;
    logic               w_accept;
    logic [31:0]        w_lfsr_next;
    logic [32:0]        w_rem_shift;
    logic [31:0]        w_rem_next;

    // Split the flat range buses into per-requester words
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_min_arr[g] = bus.req_min_i[32*g +: 32];
        assign w_max_arr[g] = bus.req_max_i[32*g +: 32];
    end

    // Round-robin pick: first pending requester after r_rr_last, cyclically
    always_comb begin
        int                 cand;
        logic [c_idx_w-1:0] cand_idx;
        w_any_req   = 1'b0;
        w_grant_idx = r_rr_last;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand     = (int'(r_rr_last) + i) % N_REQ;
            cand_idx = c_idx_w'(cand);
            if (!w_any_req && bus.req_valid_i[cand_idx]) begin
                w_any_req   = 1'b1;
                w_grant_idx = cand_idx;
            end
        end
    end

    // No grant is offered while reset is asserted
    assign w_accept    = (r_state == c_st_idle) && w_any_req && !rst;

    // Left shift with XNOR feedback from bits 31,21,1,0
    assign w_lfsr_next = {r_lfsr[30:0], ~(r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0])};

    // One restoring-remainder iteration; the running remainder stays below
    // span <= 2^32, so the result always fits in 32 bits
    assign w_rem_shift = {r_rem, r_dividend[31]};
    assign w_rem_next  = (w_rem_shift >= r_span) ? 32'(w_rem_shift - r_span)
                                                 : 32'(w_rem_shift);

    assign bus.req_ready_o = w_accept ? (c_one_hot0 << w_grant_idx) : '0;
    assign bus.rsp_valid_o = (r_state == c_st_resp) ? (c_one_hot0 << r_owner) : '0;
    assign bus.rsp_data_o  = r_rsp_data;
    assign bus.busy_o      = (r_state != c_st_idle);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> STEP -> DIV (32 cycles) -> RESP -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_next = c_st_step;
            c_st_step: w_state_next = c_st_div;
            c_st_div:  if (r_div_cnt == 5'd31) w_state_next = c_st_resp;
            c_st_resp: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Datapath: capture request, step LFSR, iterate remainder, build result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr     <= SEED;
            r_rr_last  <= c_rr_init;
            r_owner    <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_dividend <= '0;
            r_span     <= '0;
            r_rem      <= '0;
            r_bypass   <= 1'b0;
            r_div_cnt  <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_owner   <= w_grant_idx;
                        r_rr_last <= w_grant_idx;
                        r_min     <= w_min_arr[w_grant_idx];
                        r_max     <= w_max_arr[w_grant_idx];
                    end
                end
                c_st_step: begin
                    r_lfsr     <= w_lfsr_next;
                    r_dividend <= w_lfsr_next;
                    // min=0,max=FFFF_FFFF yields 2^32, hence the 33-bit span
                    r_span     <= {1'b0, r_max} - {1'b0, r_min} + 33'd1;
                    r_bypass   <= (r_max < r_min);
                    r_rem      <= '0;
                    r_div_cnt  <= '0;
                end
                c_st_div: begin
                    r_rem      <= w_rem_next;
                    r_dividend <= {r_dividend[30:0], 1'b0};
                    r_div_cnt  <= r_div_cnt + 5'd1;
                    // Inverted range still runs all iterations but returns min
                    if (r_div_cnt == 5'd31) begin
                        r_rsp_data <= r_min + (r_bypass ? 32'd0 : w_rem_next);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rand_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_rand_server
// Description : Directed self-checking bench for lfsr_rand_server: reset
//               state, full and narrow ranges, degenerate and inverted
//               ranges, round-robin order, reset during DIV, held requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_rand_server;

    localparam int          N     = 4;
    localparam logic [31:0] SEED  = 32'hAE1F_B42C;
    localparam logic [31:0] FIRST = 32'h5C3F_6858;

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [31:0] m_lfsr;

    lfsr_rand_server_if #(.N_REQ(N)) bus ();

    lfsr_rand_server #(.N_REQ(N), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] sample,
                                                 input logic [31:0] mn,
                                                 input logic [31:0] mx);
        logic [32:0] span;
        logic [32:0] rem;
        if (mx < mn) return mn;
        span = {1'b0, mx} - {1'b0, mn} + 33'd1;
        rem  = {1'b0, sample} % span;
        return mn + rem[31:0];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst             = 1'b1;
        bus.req_valid_i = '0;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_lfsr = SEED;
    endtask

    // Issues one request and observes the following 36 cycles
    task automatic issue(input int k, input logic [31:0] mn, input logic [31:0] mx,
                         output int wait_cycles, output int lat,
                         output logic [31:0] data, output logic [N-1:0] seen,
                         output int pulses);
        int ta;
        @(posedge clk); #1;
        bus.req_min_i[32*k +: 32] = mn;
        bus.req_max_i[32*k +: 32] = mx;
        bus.req_valid_i[k]        = 1'b1;
        wait_cycles = 0;
        lat         = -1;
        data        = 'x;
        seen        = '0;
        pulses      = 0;
        @(negedge clk);
        while (bus.req_ready_o[k] !== 1'b1 && wait_cycles < 100) begin
            wait_cycles++;
            @(negedge clk);
        end
        ta = cyc;
        @(posedge clk); #1;
        bus.req_valid_i[k] = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid_o;
            if (bus.rsp_valid_o !== '0) begin
                pulses++;
                if (lat < 0) begin
                    lat  = cyc - ta;
                    data = bus.rsp_data_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (bus.req_ready_o !== '0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", bus.req_ready_o);
        end
        n_checks++;
        if (bus.rsp_valid_o !== '0) begin
            n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o);
        end
        n_checks++;
        if (bus.rsp_data_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data_o);
        end
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o);
        end
    endtask

    task automatic test_full_range();
        int wc, lat, np;
        logic [31:0] d;
        logic [N-1:0] seen;
        do_reset();
        issue(0, 32'h0, 32'hFFFF_FFFF, wc, lat, d, seen, np);
        m_lfsr = lfsr_step(m_lfsr);
        n_checks++;
        if (wc !== 0) begin
            n_fail++; $display("FAIL full_ready_same_cycle: waited %0d want 0", wc);
        end
        n_checks++;
        if (lat !== 34) begin
            n_fail++; $display("FAIL full_latency: got %0d want 34", lat);
        end
        n_checks++;
        if (d !== FIRST) begin
            n_fail++; $display("FAIL full_data: got %h want %h", d, FIRST);
        end
        n_checks++;
        if (seen !== 4'b0001 || np !== 1) begin
            n_fail++; $display("FAIL full_rsp_valid: mask %b pulses %0d want 0001/1", seen, np);
        end
    endtask

    task automatic test_small_range();
        int wc, lat, np;
        logic [31:0] d;
        logic [N-1:0] seen;
        do_reset();
        issue(2, 32'd100, 32'd109, wc, lat, d, seen, np);
        m_lfsr = lfsr_step(m_lfsr);
        n_checks++;
        if (d !== 32'd102) begin
            n_fail++; $display("FAIL small_data: got %0d want 102", d);
        end
        n_checks++;
        if (lat !== 34) begin
            n_fail++; $display("FAIL small_latency: got %0d want 34", lat);
        end
        n_checks++;
        if (seen !== 4'b0100 || np !== 1) begin
            n_fail++; $display("FAIL small_rsp_valid: mask %b pulses %0d want 0100/1", seen, np);
        end
    endtask

    task automatic test_equal_and_inverted();
        int wc, lat, np;
        logic [31:0] d, exp;
        logic [N-1:0] seen;
        do_reset();
        issue(1, 32'd7, 32'd7, wc, lat, d, seen, np);
        m_lfsr = lfsr_step(m_lfsr);
        n_checks++;
        if (d !== 32'd7 || lat !== 34) begin
            n_fail++; $display("FAIL equal_range: data %0d lat %0d want 7/34", d, lat);
        end
        issue(1, 32'd20, 32'd10, wc, lat, d, seen, np);
        m_lfsr = lfsr_step(m_lfsr);
        n_checks++;
        if (d !== 32'd20 || lat !== 34) begin
            n_fail++; $display("FAIL inverted_range: data %0d lat %0d want 20/34", d, lat);
        end
        n_checks++;
        if (seen !== 4'b0010 || np !== 1) begin
            n_fail++; $display("FAIL inverted_rsp_valid: mask %b pulses %0d want 0010/1", seen, np);
        end
        // Third request exposes whether the LFSR advanced exactly twice before
        issue(1, 32'h0, 32'hFFFF_FFFF, wc, lat, d, seen, np);
        m_lfsr = lfsr_step(m_lfsr);
        exp    = m_lfsr;
        n_checks++;
        if (d !== exp) begin
            n_fail++; $display("FAIL lfsr_advance: got %h want %h", d, exp);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] mins [N];
        logic [31:0] maxs [N];
        logic [N-1:0] rdy;
        logic [31:0] exp;
        int ta, g, w;
        mins[0] = 32'h0;     maxs[0] = 32'hFFFF_FFFF;
        mins[1] = 32'd100;   maxs[1] = 32'd109;
        mins[2] = 32'd5;     maxs[2] = 32'd5;
        mins[3] = 32'd1000;  maxs[3] = 32'd1999;
        do_reset();
        for (int k = 0; k < N; k++) begin
            bus.req_min_i[32*k +: 32] = mins[k];
            bus.req_max_i[32*k +: 32] = maxs[k];
        end
        bus.req_valid_i = '1;
        for (int r = 0; r < 8; r++) begin
            w = 0;
            @(negedge clk);
            while (bus.req_ready_o === '0 && w < 100) begin
                w++;
                @(negedge clk);
            end
            rdy = bus.req_ready_o;
            ta  = cyc;
            g   = r % N;
            n_checks++;
            if (rdy !== (4'b0001 << g)) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", r, rdy, 4'b0001 << g);
            end
            w = 0;
            @(negedge clk);
            while (bus.rsp_valid_o === '0 && w < 100) begin
                w++;
                @(negedge clk);
            end
            m_lfsr = lfsr_step(m_lfsr);
            exp    = model_result(m_lfsr, mins[g], maxs[g]);
            n_checks++;
            if (cyc - ta !== 34) begin
                n_fail++; $display("FAIL rr_latency[%0d]: got %0d want 34", r, cyc - ta);
            end
            n_checks++;
            if (bus.rsp_valid_o !== (4'b0001 << g) || bus.rsp_data_o !== exp) begin
                n_fail++; $display("FAIL rr_rsp[%0d]: valid %b data %h want %b/%h",
                                   r, bus.rsp_valid_o, bus.rsp_data_o, 4'b0001 << g, exp);
            end
        end
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        int ta, np, wc, lat;
        logic [31:0] d;
        logic [N-1:0] seen;
        do_reset();
        bus.req_min_i[31:0] = 32'h0;
        bus.req_max_i[31:0] = 32'hFFFF_FFFF;
        bus.req_valid_i[0]  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            n_fail++; $display("FAIL middiv_accept: got %b want 0001", bus.req_ready_o);
        end
        ta = cyc;
        @(posedge clk); #1;
        bus.req_valid_i[0] = 1'b0;
        while (cyc < ta + 10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_lfsr = SEED;
        @(negedge clk);
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL middiv_busy_after_reset: got %b want 0", bus.busy_o);
        end
        np = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.rsp_valid_o !== '0) np++;
            @(negedge clk);
        end
        n_checks++;
        if (np !== 0) begin
            n_fail++; $display("FAIL middiv_no_pulse: got %0d pulses want 0", np);
        end
        issue(0, 32'h0, 32'hFFFF_FFFF, wc, lat, d, seen, np);
        m_lfsr = lfsr_step(m_lfsr);
        n_checks++;
        if (d !== FIRST || lat !== 34) begin
            n_fail++; $display("FAIL middiv_restart: data %h lat %0d want %h/34", d, lat, FIRST);
        end
    endtask

    task automatic test_back_to_back();
        int ta, bad_ready, bad_busy, w;
        logic [31:0] exp, d0;
        logic [N-1:0] v0;
        do_reset();
        bus.req_min_i[31:0]   = 32'h0;
        bus.req_max_i[31:0]   = 32'hFFFF_FFFF;
        bus.req_min_i[127:96] = 32'd1000;
        bus.req_max_i[127:96] = 32'd1999;
        bus.req_valid_i       = 4'b1001;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready_o !== 4'b0001 || bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first_grant: ready %b busy %b want 0001/0",
                               bus.req_ready_o, bus.busy_o);
        end
        ta = cyc;
        @(posedge clk); #1;
        bus.req_valid_i[0] = 1'b0;
        bad_ready = 0;
        bad_busy  = 0;
        v0        = '0;
        d0        = '0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (bus.req_ready_o !== '0) bad_ready++;
            if (bus.busy_o !== 1'b1) bad_busy++;
            if (c == 34) begin
                v0 = bus.rsp_valid_o;
                d0 = bus.rsp_data_o;
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
        n_checks++;
        if (bad_ready !== 0) begin
            n_fail++; $display("FAIL b2b_ready_held_low: %0d bad cycles want 0", bad_ready);
        end
        n_checks++;
        if (bad_busy !== 0) begin
            n_fail++; $display("FAIL b2b_busy_high: %0d bad cycles want 0", bad_busy);
        end
        n_checks++;
        if (v0 !== 4'b0001 || d0 !== FIRST) begin
            n_fail++; $display("FAIL b2b_first_rsp: valid %b data %h want 0001/%h", v0, d0, FIRST);
        end
        @(negedge clk);
        n_checks++;
        if (bus.req_ready_o !== 4'b1000 || cyc - ta !== 35) begin
            n_fail++; $display("FAIL b2b_second_grant: ready %b at +%0d want 1000 at +35",
                               bus.req_ready_o, cyc - ta);
        end
        ta = cyc;
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        w = 0;
        @(negedge clk);
        while (bus.rsp_valid_o === '0 && w < 100) begin
            w++;
            @(negedge clk);
        end
        m_lfsr = lfsr_step(m_lfsr);
        exp    = model_result(m_lfsr, 32'd1000, 32'd1999);
        n_checks++;
        if (bus.rsp_valid_o !== 4'b1000 || bus.rsp_data_o !== exp || cyc - ta !== 34) begin
            n_fail++; $display("FAIL b2b_second_rsp: valid %b data %h lat %0d want 1000/%h/34",
                               bus.rsp_valid_o, bus.rsp_data_o, cyc - ta, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        cyc             = 0;
        n_checks        = 0;
        n_fail          = 0;
        m_lfsr          = SEED;
        bus.req_valid_i = '0;
        bus.req_min_i   = '0;
        bus.req_max_i   = '0;
        test_reset();
        test_full_range();
        test_small_range();
        test_equal_and_inverted();
        test_round_robin();
        test_reset_mid_div();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
